// File: rtl/i2c_reg_sequencer.sv
// Register-access sequencer: turns one read/write request into the I2C/SCCB byte-command
// sequence for the downstream controller. Optional read support under I2C_SEQ_READ_EN.
module i2c_reg_sequencer #(
    parameter int unsigned GAP_CYCLES = 2,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rw,
    input  logic [6:0] req_dev,
    input  logic [7:0] req_reg,
    input  logic [7:0] req_wdat,
    output logic       ctl_flag,
    output logic [3:0] ctl_cmd,
    output logic [7:0] ctl_dat,
    input  logic       ctl_busy,
    input  logic [7:0] ctl_out_dat,
    input  logic       ctl_out_flag,
    output logic [7:0] rd_data,
    output logic       done,
    output logic       err,
    output logic       seq_busy
);

    localparam int unsigned STEP_W = 4;
    localparam int unsigned TO_W   = (TIMEOUT < 256) ? 8 : $clog2(TIMEOUT + 1);
    localparam int unsigned GAP_W  = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);

    localparam logic [3:0] CMD_START     = 4'd1;
    localparam logic [3:0] CMD_WRITE     = 4'd2;
    localparam logic [3:0] CMD_READ      = 4'd3;
    localparam logic [3:0] CMD_RECV_ACK  = 4'd4;
    localparam logic [3:0] CMD_STOP      = 4'd6;
    localparam logic [3:0] CMD_SEND_NACK = 4'd7;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_FLAG, S_WAIT, S_GAP, S_DONE, S_REJ
    } state_t;

    state_t              state, state_nxt;
    logic [STEP_W-1:0]   step, step_nxt;
    logic [TO_W-1:0]     tcnt, tcnt_nxt;
    logic [GAP_W-1:0]    gcnt, gcnt_nxt;
    logic                err_nxt;
    logic                rq_rw, rq_rw_nxt;
    logic [6:0]          rq_dev, rq_dev_nxt;
    logic [7:0]          rq_reg, rq_reg_nxt;
    logic [7:0]          rq_wdat, rq_wdat_nxt;
    logic                rd_sel, rd_sel_nxt;
    logic [STEP_W-1:0]   last_step;
    logic [11:0]         cmd_dat_nxt;

    // {cmd, dat} for one step of the write list (rd=0) or the two-phase SCCB read list (rd=1)
    function automatic logic [11:0] step_entry(input logic rd, input logic [STEP_W-1:0] idx,
                                               input logic [6:0] dev, input logic [7:0] rg,
                                               input logic [7:0] wd);
        logic [11:0] e;
        e = {CMD_STOP, 8'h00};
        unique case (idx)
            4'd0:    e = {CMD_START, 8'h00};
            4'd1:    e = {CMD_WRITE, dev, 1'b0};
            4'd2:    e = {CMD_RECV_ACK, 8'h00};
            4'd3:    e = {CMD_WRITE, rg};
            4'd4:    e = {CMD_RECV_ACK, 8'h00};
            4'd5:    e = rd ? {CMD_STOP, 8'h00} : {CMD_WRITE, wd};
            4'd6:    e = rd ? {CMD_START, 8'h00} : {CMD_RECV_ACK, 8'h00};
            4'd7:    e = rd ? {CMD_WRITE, dev, 1'b1} : {CMD_STOP, 8'h00};
            4'd8:    e = {CMD_RECV_ACK, 8'h00};
            4'd9:    e = {CMD_READ, 8'h00};
            4'd10:   e = {CMD_SEND_NACK, 8'h00};
            default: e = {CMD_STOP, 8'h00};
        endcase
        return e;
    endfunction

`ifdef I2C_SEQ_READ_EN
    assign rd_sel     = rq_rw;
    assign rd_sel_nxt = rq_rw_nxt;
`else
    assign rd_sel     = 1'b0;
    assign rd_sel_nxt = 1'b0;
`endif
    assign last_step = rd_sel ? STEP_W'(11) : STEP_W'(7);

    // Next-state, counters and request capture
    always_comb begin
        state_nxt   = state;
        step_nxt    = step;
        tcnt_nxt    = tcnt;
        gcnt_nxt    = gcnt;
        err_nxt     = 1'b0;
        rq_rw_nxt   = rq_rw;
        rq_dev_nxt  = rq_dev;
        rq_reg_nxt  = rq_reg;
        rq_wdat_nxt = rq_wdat;
        unique case (state)
            S_IDLE: begin
                if (req_valid) begin
                    rq_rw_nxt   = req_rw;
                    rq_dev_nxt  = req_dev;
                    rq_reg_nxt  = req_reg;
                    rq_wdat_nxt = req_wdat;
                    step_nxt    = '0;
`ifdef I2C_SEQ_READ_EN
                    state_nxt   = S_LOAD;
`else
                    state_nxt   = req_rw ? S_REJ : S_LOAD;
`endif
                end
            end
            S_REJ: begin
                state_nxt = S_DONE;
                err_nxt   = 1'b1;
            end
            S_LOAD: begin
                state_nxt = S_FLAG;
                tcnt_nxt  = '0;
            end
            S_FLAG: state_nxt = S_WAIT;
            S_WAIT: begin
                if (!ctl_busy) begin
                    state_nxt = S_GAP;
                    gcnt_nxt  = '0;
                end else if (tcnt == TO_W'(TIMEOUT - 1)) begin
                    state_nxt = S_DONE;
                    err_nxt   = 1'b1;
                end else begin
                    tcnt_nxt = tcnt + TO_W'(1);
                end
            end
            S_GAP: begin
                if (gcnt == GAP_W'(GAP_CYCLES - 1)) begin
                    if (step == last_step) begin
                        state_nxt = S_DONE;
                    end else begin
                        step_nxt  = step + STEP_W'(1);
                        state_nxt = S_LOAD;
                    end
                end else begin
                    gcnt_nxt = gcnt + GAP_W'(1);
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // cmd/dat are presented from LOAD through the end of WAIT and are zero elsewhere
    always_comb begin
        cmd_dat_nxt = '0;
        if (state_nxt == S_LOAD || state_nxt == S_FLAG || state_nxt == S_WAIT)
            cmd_dat_nxt = step_entry(rd_sel_nxt, step_nxt, rq_dev_nxt, rq_reg_nxt, rq_wdat_nxt);
    end

    always_ff @(posedge sys_clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            step      <= '0;
            tcnt      <= '0;
            gcnt      <= '0;
            rq_rw     <= 1'b0;
            rq_dev    <= '0;
            rq_reg    <= '0;
            rq_wdat   <= '0;
            ctl_flag  <= 1'b0;
            ctl_cmd   <= '0;
            ctl_dat   <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            seq_busy  <= 1'b0;
            req_ready <= 1'b1;
        end else begin
            state     <= state_nxt;
            step      <= step_nxt;
            tcnt      <= tcnt_nxt;
            gcnt      <= gcnt_nxt;
            rq_rw     <= rq_rw_nxt;
            rq_dev    <= rq_dev_nxt;
            rq_reg    <= rq_reg_nxt;
            rq_wdat   <= rq_wdat_nxt;
            ctl_flag  <= (state_nxt == S_FLAG);
            ctl_cmd   <= cmd_dat_nxt[11:8];
            ctl_dat   <= cmd_dat_nxt[7:0];
            done      <= (state_nxt == S_DONE);
            err       <= err_nxt;
            seq_busy  <= (state_nxt != S_IDLE) && (state_nxt != S_DONE);
            req_ready <= (state_nxt == S_IDLE);
        end
    end

`ifdef I2C_SEQ_READ_EN
    logic out_flag_q;

    // Read byte is taken only on a fresh controller completion during the READ step
    always_ff @(posedge sys_clk) begin
        if (!rst) begin
            out_flag_q <= 1'b0;
            rd_data    <= '0;
        end else begin
            out_flag_q <= ctl_out_flag;
            if (ctl_out_flag && !out_flag_q && ctl_cmd == CMD_READ)
                rd_data <= ctl_out_dat;
        end
    end
`else
    logic unused_rd;
    assign unused_rd = ^{ctl_out_dat, ctl_out_flag};
    assign rd_data   = '0;
`endif

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Directed self-checking bench for i2c_reg_sequencer with a simple busy-counting controller model.
module tb_i2c_reg_sequencer;

    logic       sys_clk;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic       req_rw;
    logic [6:0] req_dev;
    logic [7:0] req_reg;
    logic [7:0] req_wdat;
    logic       ctl_flag;
    logic [3:0] ctl_cmd;
    logic [7:0] ctl_dat;
    logic       ctl_busy;
    logic [7:0] ctl_out_dat;
    logic       ctl_out_flag;
    logic [7:0] rd_data;
    logic       done;
    logic       err;
    logic       seq_busy;

    i2c_reg_sequencer dut (
        .sys_clk     (sys_clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_rw      (req_rw),
        .req_dev     (req_dev),
        .req_reg     (req_reg),
        .req_wdat    (req_wdat),
        .ctl_flag    (ctl_flag),
        .ctl_cmd     (ctl_cmd),
        .ctl_dat     (ctl_dat),
        .ctl_busy    (ctl_busy),
        .ctl_out_dat (ctl_out_dat),
        .ctl_out_flag(ctl_out_flag),
        .rd_data     (rd_data),
        .done        (done),
        .err         (err),
        .seq_busy    (seq_busy)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Controller model: busy for busy_len cycles after each flag; optional hang on a given flag
    int   busy_len    = 0;
    int   hang_target = -1;
    logic hang_on     = 1'b0;
    int   bcnt        = 0;
    int   nflags      = 0;
    int   consec      = 0;
    int   ready_bad   = 0;
    logic prev_flag   = 1'b0;
    logic [3:0] cmd_log [0:127];
    logic [7:0] dat_log [0:127];
    int         flag_cyc[0:127];

    assign ctl_busy = (bcnt != 0) || hang_on;

    always @(posedge sys_clk) begin
        cyc          <= cyc + 1;
        ctl_out_flag <= (bcnt == 2) && (ctl_cmd == 4'd3);
        if (ctl_flag) bcnt <= busy_len;
        else if (bcnt != 0) bcnt <= bcnt - 1;
        if (hang_target < 0) hang_on <= 1'b0;
        else if (ctl_flag && nflags == hang_target) hang_on <= 1'b1;
    end

    always @(negedge sys_clk) begin
        if (ctl_flag) begin
            if (nflags < 128) begin
                cmd_log[nflags]  = ctl_cmd;
                dat_log[nflags]  = ctl_dat;
                flag_cyc[nflags] = cyc;
            end
            nflags++;
        end
        if (ctl_flag && prev_flag) consec++;
        prev_flag = ctl_flag;
        if (seq_busy && req_ready) ready_bad++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request from a negedge with req_ready=1; returns at the negedge after done
    task automatic run_req(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                           input logic [7:0] wd, output int lat, output logic err_o,
                           output int done_cyc);
        req_rw = rw; req_dev = dev; req_reg = rg; req_wdat = wd; req_valid = 1'b1;
        @(negedge sys_clk);
        req_valid = 1'b0;
        lat = 1;
        while (!done && lat < 2000) begin
            @(negedge sys_clk);
            lat++;
        end
        check("done_seen", done, 1);
        err_o    = err;
        done_cyc = cyc;
        check("busy_low_at_done", seq_busy, 0);
        @(negedge sys_clk);
        check("ready_after_done", req_ready, 1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, req_ready, 1);
        check({tag, "_flag"}, ctl_flag, 0);
        check({tag, "_cmd"}, ctl_cmd, 0);
        check({tag, "_dat"}, ctl_dat, 0);
        check({tag, "_rd_data"}, rd_data, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_busy"}, seq_busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat, base, dcyc, acc2, i, k, rb0, dseen;
        logic e;
        logic [3:0] wr_cmds [0:7];
        logic [7:0] wr_dats [0:7];
        logic [3:0] rd_cmds [0:11];
        wr_cmds = '{4'd1, 4'd2, 4'd4, 4'd2, 4'd4, 4'd2, 4'd4, 4'd6};
        wr_dats = '{8'h00, 8'h42, 8'h00, 8'h12, 8'h00, 8'h80, 8'h00, 8'h00};
        rd_cmds = '{4'd1, 4'd2, 4'd4, 4'd2, 4'd4, 4'd6, 4'd1, 4'd2, 4'd4, 4'd3, 4'd7, 4'd6};

        rst = 1'b0; req_valid = 1'b0; req_rw = 1'b0; req_dev = '0; req_reg = '0;
        req_wdat = '0; ctl_out_dat = 8'h76;
        repeat (3) @(negedge sys_clk);
        check_reset_vals("reset");
        rst = 1'b1;
        @(negedge sys_clk);

        // Write with an instantly idle controller: 8 steps x 5 cycles, +1 for DONE
        busy_len = 0; base = nflags;
        run_req(1'b0, 7'h21, 8'h12, 8'h80, lat, e, dcyc);
        check("wr_fast_latency", lat, 41);
        check("wr_fast_err", e, 0);
        check("wr_fast_nflags", nflags - base, 8);

        // Write with 18-cycle busy: 8 steps x (1+1+19+2), +1
        busy_len = 18; base = nflags;
        run_req(1'b0, 7'h21, 8'h12, 8'h80, lat, e, dcyc);
        check("wr_latency", lat, 185);
        check("wr_err", e, 0);
        check("wr_nflags", nflags - base, 8);
        for (i = 0; i < 8; i++) begin
            check($sformatf("wr_cmd%0d", i), cmd_log[base + i], wr_cmds[i]);
            check($sformatf("wr_dat%0d", i), dat_log[base + i], wr_dats[i]);
        end

`ifdef I2C_SEQ_READ_EN
        base = nflags;
        run_req(1'b1, 7'h21, 8'h0A, 8'h00, lat, e, dcyc);
        check("rd_latency", lat, 277);
        check("rd_err", e, 0);
        check("rd_nflags", nflags - base, 12);
        for (i = 0; i < 12; i++)
            check($sformatf("rd_cmd%0d", i), cmd_log[base + i], rd_cmds[i]);
        check("rd_addr1", dat_log[base + 1], 8'h42);
        check("rd_addr2", dat_log[base + 7], 8'h43);
        check("rd_data", rd_data, 8'h76);
`else
        base = nflags;
        run_req(1'b1, 7'h21, 8'h0A, 8'h00, lat, e, dcyc);
        check("rej_latency", lat, 2);
        check("rej_err", e, 1);
        check("rej_nflags", nflags - base, 0);
        check("rej_rd_data", rd_data, 0);
        check("rej_cmd_idle", rd_cmds[9], 4'd3);
`endif

        // Controller hangs on the third command: 255 WAIT cycles then DONE with err
        base = nflags; hang_target = base + 3;
        run_req(1'b0, 7'h21, 8'h12, 8'h80, lat, e, dcyc);
        check("to_err", e, 1);
        check("to_nflags", nflags - base, 3);
        check("to_wait_cycles", dcyc - flag_cyc[base + 2], 256);
        repeat (10) @(negedge sys_clk);
        check("to_no_more_flags", nflags - base, 3);
        hang_target = -1;
        repeat (2) @(negedge sys_clk);

        // Reset while waiting on step 5 of a write
        base = nflags;
        req_rw = 1'b0; req_dev = 7'h21; req_reg = 8'h12; req_wdat = 8'h80; req_valid = 1'b1;
        @(negedge sys_clk);
        req_valid = 1'b0;
        k = 0;
        while (nflags - base < 6 && k < 1000) begin
            @(negedge sys_clk);
            k++;
        end
        check("rst_reached_step5", nflags - base, 6);
        repeat (3) @(negedge sys_clk);
        rst = 1'b0;
        @(negedge sys_clk);
        check_reset_vals("midrst");
        rst = 1'b1;
        dseen = 0;
        repeat (30) begin
            @(negedge sys_clk);
            if (done) dseen++;
        end
        check("midrst_no_done", dseen, 0);
        check("midrst_no_flags", nflags - base, 6);
        base = nflags;
        run_req(1'b0, 7'h21, 8'h12, 8'h80, lat, e, dcyc);
        check("post_rst_latency", lat, 185);
        check("post_rst_err", e, 0);
        check("post_rst_nflags", nflags - base, 8);

        // req_valid held high across two requests; data changed after first acceptance
        busy_len = 0; base = nflags; rb0 = ready_bad;
        req_rw = 1'b0; req_dev = 7'h21; req_reg = 8'h12; req_wdat = 8'h55; req_valid = 1'b1;
        @(negedge sys_clk);
        req_wdat = 8'h66;
        k = 0;
        while (!done && k < 500) begin
            @(negedge sys_clk);
            k++;
        end
        check("b2b_done1", done, 1);
        dcyc = cyc;
        acc2 = -1;
        k = 0;
        while (acc2 < 0 && k < 50) begin
            @(negedge sys_clk);
            if (req_ready && req_valid) acc2 = cyc;
            k++;
        end
        @(negedge sys_clk);
        req_valid = 1'b0;
        check("b2b_accept_after_done", acc2 - dcyc, 1);
        k = 0;
        while (!done && k < 500) begin
            @(negedge sys_clk);
            k++;
        end
        check("b2b_done2", done, 1);
        check("b2b_nflags", nflags - base, 16);
        check("b2b_wdat1", dat_log[base + 5], 8'h55);
        check("b2b_wdat2", dat_log[base + 13], 8'h66);
        check("b2b_ready_low_busy", ready_bad - rb0, 0);
        check("no_consecutive_flags", consec, 0);
        repeat (3) @(negedge sys_clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/i2c_reg_sequencer.md
Name: i2c_reg_sequencer

Overview:
Transaction-level front end that sits directly upstream of the byte-level I2C/SCCB command controller. It accepts one register-access request and issues the byte-command sequence (START/WRITE/RECV_ACK/READ/SEND_NACK/STOP) over the controller's flag/cmd/dat interface. It waits for controller busy between steps and returns read data. Typical user: camera/sensor register init ROM walker.

Parameters:
GAP_CYCLES, 2, idle cycles inserted after controller busy drops before next command (min 1)
TIMEOUT, 255, max cycles waiting on ctl_busy per step before abort with err

Ports:
sys_clk  input  1  system clock
rst  input  1  synchronous active-low reset
req_valid  input  1  request strobe, accepted when req_ready=1
req_ready  output  1  high in IDLE only
req_rw  input  1  0=write, 1=read
req_dev  input  7  7-bit device address
req_reg  input  8  register address
req_wdat  input  8  write data (ignored for read)
ctl_flag  output  1  command strobe to controller (controller acts on rising edge)
ctl_cmd  output  4  command code: START=1, WRITE=2, READ=3, RECV_ACK=4, SEND_ACK=5, STOP=6, SEND_NACK=7
ctl_dat  output  8  byte for WRITE commands, 0 otherwise
ctl_busy  input  1  controller busy
ctl_out_dat  input  8  controller read byte
ctl_out_flag  input  1  controller read-complete flag
rd_data  output  8  last read byte, held until next read completes
done  output  1  one-cycle pulse at end of transaction
err  output  1  valid with done; 1 = timeout or rejected request
seq_busy  output  1  high from request acceptance to done

Behaviour:
- One clock sys_clk; reset is synchronous and active-low on rst. Reset: state IDLE, step=0, ctl_flag=0, ctl_cmd=0, ctl_dat=0, rd_data=0, done=0, err=0, seq_busy=0, req_ready=1. Reset mid-transaction aborts immediately with no done pulse; ctl_flag forced 0.
- Request latched (rw, dev, reg, wdat) on req_valid&&req_ready; inputs ignored otherwise.
- Write step list (8): START, WRITE{dev,0}, RECV_ACK, WRITE reg, RECV_ACK, WRITE wdat, RECV_ACK, STOP.
- Read step list (12, SCCB two-phase): START, WRITE{dev,0}, RECV_ACK, WRITE reg, RECV_ACK, STOP, START, WRITE{dev,1}, RECV_ACK, READ, SEND_NACK, STOP.
- FSM: IDLE -> LOAD (drive ctl_cmd/ctl_dat for step, flag 0) -> FLAG (ctl_flag=1 exactly one cycle, cmd/dat stable) -> WAIT (ctl_flag=0; hold cmd/dat; stay while ctl_busy=1) -> GAP (GAP_CYCLES cycles) -> LOAD next step, or DONE after last step -> IDLE.
- ctl_cmd/ctl_dat stable from LOAD through end of WAIT; ctl_flag never high two consecutive cycles; ≥1 low cycle between flags.
- WAIT: on first cycle ctl_busy is sampled; exit when ctl_busy=0. Timeout counter (8+ bits, cleared in LOAD) reaching TIMEOUT in WAIT -> DONE with err=1, remaining steps skipped, no STOP issued.
- rd_data captured on rising edge of ctl_out_flag during READ step only (edge-detected, register of prior value reset to 0).
- DONE: done=1 one cycle, err valid same cycle; seq_busy drops the same cycle; req_ready=1 next cycle. Back-to-back requests: minimum 1 idle cycle between done and next acceptance.
- Latency, write with controller instant-idle: per step LOAD+FLAG+WAIT(≥1)+GAP.

Optional Feature:
Macro I2C_SEQ_READ_EN. Defined: read list above supported, rd_data/capture logic present. Undefined: read logic removed; request with req_rw=1 is accepted, no ctl_flag issued, done=1 err=1 exactly 2 cycles after acceptance; rd_data constant 0.

Test Plan:
- Write dev=0x21 reg=0x12 wdat=0x80, controller model busy 18 cycles per step -> 8 flags, ctl_dat sequence 0x42,0x12,0x80 on WRITE steps, cmd order 1,2,4,2,4,2,4,6; done=1 err=0.
- Read (READ_EN) dev=0x21 reg=0x0A, model returns 0x76 -> 12 flags, second address byte 0x43, rd_data=0x76 at done, err=0.
- Model holds ctl_busy high forever on step 2, TIMEOUT=255 -> done with err=1 exactly 255 WAIT cycles later, no further flags.
- rst=0 asserted during step 5 of write -> next cycle all outputs at reset values, no done; fresh request afterwards completes normally.
- req_valid held high continuously for two requests -> second accepted only after done, req_ready=0 throughout first.
- READ_EN undefined, req_rw=1 -> zero ctl_flag pulses, done=1 err=1 two cycles after acceptance.
